// File: rtl/spi_pkg.sv
// Shared definitions for the SPI chip-select arbiter: FSM state encoding,
// default timing constants and the chip-select pattern helper.
package spi_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_START = 3'd2,
      S_BUSY  = 3'd3,
      S_NEXT  = 3'd4,
      S_HOLD  = 3'd5
   } state_t;

   localparam int CS_SETUP_DEF   = 2;
   localparam int CS_HOLD_DEF    = 1;
   localparam int LOCK_LIMIT_DEF = 65535;

   // Active-low chip-select pattern selecting a single requester.
   function automatic logic [1:0] cs_pattern(input logic sel);
      return sel ? 2'b01 : 2'b10;
   endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// Link between the arbiter and the SPI engine, plus the chip selects.
// master: arbiter side, slave: engine / device side.
interface spi_arbiter_if;
   logic        spi_start;
   logic        spi_fast;
   logic [31:0] spi_tx;
   logic        spi_rdy;
   logic [31:0] spi_rx;
   logic [1:0]  ss_n;

   modport master (output spi_start, spi_fast, spi_tx, ss_n,
                   input  spi_rdy, spi_rx);
   modport slave  (input  spi_start, spi_fast, spi_tx, ss_n,
                   output spi_rdy, spi_rx);
endinterface

// File: rtl/spi_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the requester granted last loses.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       grant,
   output logic       valid
);

   // Pure combinational pick; the caller registers the result.
   always_comb begin
      valid = |req;
      grant = (req[0] & req[1]) ? ~last : req[1];
   end

endmodule

// File: rtl/spi_arbiter.sv
// Two-requester SPI arbiter with chip-select setup/hold timing and
// transfer locking. Optional build macro SPI_ARB_LOCK_TIMEOUT_EN adds a
// lock-chain limit so a locking requester cannot starve the other one.
//
// state | meaning
// IDLE  | no chip select; arbitrate when a req is up and the engine is ready
// SETUP | chip select low, counting CS_SETUP cycles
// START | one-cycle start pulse to the engine
// BUSY  | waiting for engine rdy (first cycle ignored)
// NEXT  | done pulse visible; decide locked follow-on or release
// HOLD  | chip select held CS_HOLD cycles, then back to IDLE
module spi_arbiter
   import spi_pkg::*;
#(
   parameter int CS_SETUP = CS_SETUP_DEF,
   parameter int CS_HOLD  = CS_HOLD_DEF
`ifdef SPI_ARB_LOCK_TIMEOUT_EN
   ,
   parameter int LOCK_LIMIT = LOCK_LIMIT_DEF
`endif
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic         req1,
   input  logic         lock0,
   input  logic         lock1,
   input  logic         fast0,
   input  logic         fast1,
   input  logic [31:0]  tx0,
   input  logic [31:0]  tx1,
   output logic         done0,
   output logic         done1,
   output logic [31:0]  rx,
   spi_arbiter_if.master bus
);

   state_t     state, state_nxt;
   logic       grant, last;
   logic       arb_grant, arb_valid;
   logic       busy_first, lock_q, timeout;
   logic [3:0] cnt;
   logic [1:0] req_v, lock_v, done_q;

   assign req_v  = {req1, req0};
   assign lock_v = {lock1, lock0};
   assign done0  = done_q[0];
   assign done1  = done_q[1];

   rr_arb2 u_rr (
      .req   (req_v),
      .last  (last),
      .grant (arb_grant),
      .valid (arb_valid)
   );

`ifdef SPI_ARB_LOCK_TIMEOUT_EN
   logic [15:0] lock_cnt;

   // Count locked follow-on transfers within one grant; cleared between grants.
   always_ff @(posedge clk) begin
      if (rst || state == S_IDLE)
         lock_cnt <= '0;
      else if (state == S_NEXT && state_nxt == S_START && lock_cnt != 16'hFFFF)
         lock_cnt <= lock_cnt + 16'd1;
   end

   assign timeout = (lock_cnt >= 16'(LOCK_LIMIT - 1)) && req_v[~grant];
`else
   assign timeout = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state decision.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (arb_valid && bus.spi_rdy) state_nxt = S_SETUP;
         S_SETUP: if (cnt <= 4'd1) state_nxt = S_START;
         S_START: state_nxt = S_BUSY;
         S_BUSY:  if (!busy_first && bus.spi_rdy) state_nxt = S_NEXT;
         S_NEXT:  state_nxt = (lock_q && req_v[grant] && !timeout) ? S_START : S_HOLD;
         S_HOLD:  if (cnt <= 4'd1) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Grant, timing counter, receive capture and done pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant      <= 1'b0;
         last       <= 1'b1;
         cnt        <= '0;
         busy_first <= 1'b0;
         lock_q     <= 1'b0;
         done_q     <= '0;
         rx         <= '0;
      end else begin
         done_q <= '0;
         case (state)
            S_IDLE: begin
               if (arb_valid && bus.spi_rdy) begin
                  grant <= arb_grant;
                  cnt   <= 4'(CS_SETUP);
               end
            end
            S_SETUP: if (cnt > 4'd1) cnt <= cnt - 4'd1;
            S_START: busy_first <= 1'b1;
            S_BUSY: begin
               busy_first <= 1'b0;
               if (!busy_first && bus.spi_rdy) begin
                  rx            <= bus.spi_rx;
                  done_q[grant] <= 1'b1;
                  lock_q        <= lock_v[grant];
               end
            end
            S_NEXT: cnt <= 4'(CS_HOLD);
            S_HOLD: begin
               if (cnt > 4'd1) cnt <= cnt - 4'd1;
               else            last <= grant;
            end
            default: ;
         endcase
      end
   end

   // Engine-side outputs and chip selects; HOLD with an exhausted count
   // (CS_HOLD = 0) already releases the select.
   always_comb begin
      bus.spi_start = (state == S_START);
      bus.spi_fast  = grant ? fast1 : fast0;
      bus.spi_tx    = grant ? tx1 : tx0;
      bus.ss_n      = 2'b11;
      if (state != S_IDLE && !(state == S_HOLD && cnt == 4'd0))
         bus.ss_n = cs_pattern(grant);
   end

endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter: requester agents push expected receive
// words, a negedge monitor checks done/rx, round-robin order and CS timing.
module tb_spi_arbiter;

   localparam int CS_SETUP = 3;
   localparam int CS_HOLD  = 1;

   typedef struct { int g; int n; } sess_t;

   logic        clk, rst;
   logic [1:0]  req, lock, fast;
   logic [31:0] tx [2];
   logic        done0, done1;
   logic [31:0] rx;
   logic [1:0]  done_v;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_q0[$];
   logic [31:0] exp_q1[$];
   sess_t       sess_q[$];

   spi_arbiter_if bus();

   spi_arbiter #(
      .CS_SETUP (CS_SETUP),
      .CS_HOLD  (CS_HOLD)
`ifdef SPI_ARB_LOCK_TIMEOUT_EN
      ,
      .LOCK_LIMIT (4)
`endif
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .req0  (req[0]),
      .req1  (req[1]),
      .lock0 (lock[0]),
      .lock1 (lock[1]),
      .fast0 (fast[0]),
      .fast1 (fast[1]),
      .tx0   (tx[0]),
      .tx1   (tx[1]),
      .done0 (done0),
      .done1 (done1),
      .rx    (rx),
      .bus   (bus)
   );

   assign done_v = {done1, done0};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   // Engine receive word: word mode swaps halves, byte mode keeps the low byte.
   function automatic logic [31:0] eng_rx(input logic [31:0] t, input logic f);
      return f ? {t[15:0], t[31:16]} : {24'h0, t[7:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic tfail(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: got timeout required DUT event", name);
   endtask

   // Behavioural SPI engine peer, reset by the same rst.
   initial begin
      logic [31:0] eng_val;
      int          eng_cnt;
      bit          eng_busy;
      eng_busy = 0; eng_cnt = 0; eng_val = '0;
      bus.spi_rdy = 1'b1;
      bus.spi_rx  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            eng_busy = 0;
            bus.spi_rdy = 1'b1;
         end else if (eng_busy) begin
            if (eng_cnt == 0) begin
               bus.spi_rdy = 1'b1;
               bus.spi_rx  = eng_val;
               eng_busy    = 0;
            end else eng_cnt--;
         end else if (bus.spi_start) begin
            eng_val     = eng_rx(bus.spi_tx, bus.spi_fast);
            eng_cnt     = $urandom_range(0, 3);
            bus.spi_rdy = 1'b0;
            bus.spi_rx  = 32'hDEAD_BEEF;
            eng_busy    = 1;
         end
      end
   end

   // Monitor: round-robin model, CS timing, scoreboard pops on done.
   initial begin
      logic [1:0]  prev_ss, ss;
      logic [31:0] exp;
      bit          prev_start, in_sess, setup_act, hold_act;
      int          model_last, cur_g, exp_g, sdone, scnt, hcnt, di;
      prev_ss = 2'b11; prev_start = 0; in_sess = 0; setup_act = 0; hold_act = 0;
      model_last = 1; cur_g = 0; sdone = 0; scnt = 0; hcnt = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            model_last = 1; in_sess = 0; setup_act = 0; hold_act = 0;
            prev_ss = 2'b11; prev_start = 0;
            continue;
         end
         ss = bus.ss_n;
         check("ss_n_both_low", 32'(ss == 2'b00), 0);
         if (prev_ss == 2'b11 && ss != 2'b11) begin
            exp_g = (req == 2'b11) ? 1 - model_last : (req[1] ? 1 : 0);
            cur_g = (ss == 2'b01) ? 1 : 0;
            check("grant_round_robin", cur_g, exp_g);
            in_sess = 1; sdone = 0; setup_act = 1; scnt = 0;
         end else if (setup_act) scnt++;
         if (bus.spi_start) begin
            check("start_with_cs", 32'(ss != 2'b11), 1);
            check("start_one_cycle", 32'(prev_start), 0);
            if (setup_act) begin
               check("setup_cycles", scnt, CS_SETUP);
               setup_act = 0;
            end
            hold_act = 0;
         end
         if (done_v != 2'b00) begin
            check("done_both", 32'(done_v == 2'b11), 0);
            di = done1 ? 1 : 0;
            check("done_owner", di, cur_g);
            if ((di == 0 && exp_q0.size() == 0) || (di == 1 && exp_q1.size() == 0)) begin
               tfail("done_unexpected");
            end else begin
               exp = (di == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
               check("rx_data", rx, exp);
            end
            sdone++;
            hold_act = 1; hcnt = 0;
         end else if (hold_act && !bus.spi_start) begin
            if (ss != 2'b11) hcnt++;
            else begin
               check("hold_cycles", hcnt, CS_HOLD);
               hold_act = 0;
            end
         end
         if (prev_ss != 2'b11 && ss == 2'b11) begin
            if (in_sess) sess_q.push_back('{cur_g, sdone});
            model_last = cur_g;
            in_sess = 0;
         end
         prev_ss = ss;
         prev_start = bus.spi_start;
      end
   end

   // Requester agent: n transfers, lock held on all but the last one.
   task automatic agent(input int i, input int n, input bit drop, input bit rnd,
                        input logic [31:0] t_fix, input logic f_fix);
      logic [31:0] t;
      logic        f;
      bit          got;
      for (int k = 0; k < n; k++) begin
         t = rnd ? $urandom : t_fix;
         f = rnd ? 1'($urandom_range(0, 1)) : f_fix;
         tx[i] = t; fast[i] = f; lock[i] = (k < n - 1); req[i] = 1'b1;
         if (i == 0) exp_q0.push_back(eng_rx(t, f));
         else        exp_q1.push_back(eng_rx(t, f));
         if (drop) begin
            got = 0;
            for (int c = 0; c < 500 && !got; c++) begin
               @(negedge clk);
               if (bus.spi_start && bus.ss_n[i] == 1'b0) got = 1;
            end
            if (!got) tfail("drop_start_wait");
            @(negedge clk);
            #1 req[i] = 1'b0;
         end
         got = 0;
         for (int c = 0; c < 2000 && !got; c++) begin
            @(negedge clk);
            if (done_v[i]) got = 1;
         end
         if (!got) tfail("done_wait");
         #1;
      end
      req[i] = 1'b0;
      lock[i] = 1'b0;
   endtask

   task automatic wait_idle();
      int quiet;
      quiet = 0;
      for (int c = 0; c < 2000 && quiet < 3; c++) begin
         @(negedge clk);
         if (bus.ss_n == 2'b11) quiet++;
         else quiet = 0;
      end
      if (quiet < 3) tfail("idle_wait");
      #1;
   endtask

   task automatic expect_sess(input string name, input int g, input int n);
      sess_t s;
      if (sess_q.size() == 0) tfail(name);
      else begin
         s = sess_q.pop_front();
         check({name, "_grant"}, s.g, g);
         check({name, "_dones"}, s.n, n);
      end
   endtask

   initial begin
      bit got;
      int dcount;
      rst = 1'b1; req = '0; lock = '0; fast = '0;
      tx[0] = '0; tx[1] = '0;
      repeat (3) @(negedge clk);
      check("reset_ss_n", bus.ss_n, 2'b11);
      check("reset_start", bus.spi_start, 0);
      check("reset_done", done_v, 0);
      check("reset_rx", rx, 0);
      #1 rst = 1'b0;

      // Simultaneous requests after reset: requester 0 first.
      sess_q.delete();
      fork
         agent(0, 1, 0, 0, 32'hA5, 1'b0);
         agent(1, 1, 0, 0, 32'h5A, 1'b0);
      join
      wait_idle();
      expect_sess("tie_first", 0, 1);
      expect_sess("tie_second", 1, 1);
      check("tie_sess_left", sess_q.size(), 0);

      // Locked chain of three on requester 0 while requester 1 waits.
      fork
         agent(0, 3, 0, 1, '0, 1'b0);
         agent(1, 1, 0, 1, '0, 1'b0);
      join
      wait_idle();
      expect_sess("lock_chain", 0, 3);
      expect_sess("lock_after", 1, 1);
      check("lock_sess_left", sess_q.size(), 0);

      // Requester 1 drops req during BUSY; transfer still completes.
      agent(1, 1, 1, 1, '0, 1'b0);
      wait_idle();
      expect_sess("drop", 1, 1);
      check("drop_sess_left", sess_q.size(), 0);
      check("drop_idle_ss_n", bus.ss_n, 2'b11);

`ifdef SPI_ARB_LOCK_TIMEOUT_EN
      // Lock limit of four forces a hand-over to the pending requester.
      fork
         agent(0, 6, 0, 1, '0, 1'b0);
         agent(1, 1, 0, 1, '0, 1'b0);
      join
      wait_idle();
      expect_sess("timeout_first", 0, 4);
      expect_sess("timeout_other", 1, 1);
      expect_sess("timeout_rest", 0, 2);
`endif

      // Reset during BUSY aborts without a done pulse.
      sess_q.delete();
      tx[0] = 32'h1234_5678; fast[0] = 1'b1; lock[0] = 1'b0; req[0] = 1'b1;
      got = 0;
      for (int c = 0; c < 200 && !got; c++) begin
         @(negedge clk);
         if (bus.spi_start) got = 1;
      end
      if (!got) tfail("rst_start_wait");
      @(negedge clk);
      #1 rst = 1'b1; req[0] = 1'b0;
      @(negedge clk);
      check("rst_busy_ss_n", bus.ss_n, 2'b11);
      check("rst_busy_start", bus.spi_start, 0);
      check("rst_busy_done", done_v, 0);
      check("rst_busy_rx", rx, 0);
      #1 rst = 1'b0;
      dcount = 0;
      repeat (6) begin
         @(negedge clk);
         if (done_v != 2'b00) dcount++;
      end
      check("rst_no_done", dcount, 0);
      check("rst_no_session", sess_q.size(), 0);
      #1;

      // Randomised traffic from both requesters.
      fork
         begin
            for (int r = 0; r < 25; r++) begin
               repeat ($urandom_range(0, 4)) @(negedge clk);
               #1 agent(0, $urandom_range(1, 3), 0, 1, '0, 1'b0);
            end
         end
         begin
            for (int r = 0; r < 25; r++) begin
               repeat ($urandom_range(0, 4)) @(negedge clk);
               #1 agent(1, $urandom_range(1, 3), 0, 1, '0, 1'b0);
            end
         end
      join
      wait_idle();
      check("exp_q0_drained", exp_q0.size(), 0);
      check("exp_q1_drained", exp_q1.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
